// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
package regfile_pkg;

   localparam int unsigned DEF_DATA_W   = 64;
   localparam int unsigned DEF_NUM_REGS = 32;
   localparam int unsigned DEF_NUM_RD   = 2;
   localparam int unsigned DEF_ZERO_REG = 31;

   typedef enum logic [1:0] {
      CLR_IDLE  = 2'd0,
      CLR_SWEEP = 2'd1,
      CLR_DONE  = 2'd2
   } clr_state_t;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port and bulk-clear handshake.
interface regfile_if import regfile_pkg::*; #(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_RD   = DEF_NUM_RD
);
   localparam int unsigned ADDR_W = $clog2(NUM_REGS);

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     clr_req;
   logic                     clr_busy;
   logic                     clr_done;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, clr_req,
      input  rd_data, clr_busy, clr_done
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
      output rd_data, clr_busy, clr_done
   );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks every implemented register once, then pulses clr_done.
module regfile_clr_fsm import regfile_pkg::*; #(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic                clr_done,
   output logic [NUM_REGS-1:0] clr_vec_c
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

   clr_state_t        state;
   logic [ADDR_W-1:0] ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= CLR_IDLE;
         ptr      <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         case (state)
            CLR_IDLE: begin
               clr_done <= 1'b0;
               if (clr_req) begin
                  state    <= CLR_SWEEP;
                  ptr      <= '0;
                  clr_busy <= 1'b1;
               end
            end
            CLR_SWEEP: begin
               if (ptr == LAST_PTR) begin
                  state    <= CLR_DONE;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
               end else begin
                  ptr <= ptr + ADDR_W'(1);
               end
            end
            CLR_DONE: begin
               state    <= CLR_IDLE;
               clr_done <= 1'b0;
            end
            default: begin
               state    <= CLR_IDLE;
               clr_busy <= 1'b0;
               clr_done <= 1'b0;
            end
         endcase
      end
   end

   // One-hot strobe selecting the register cleared at the coming edge.
   always_comb begin
      clr_vec_c = '0;
      if (state == CLR_SWEEP) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            clr_vec_c[i] = (32'(ptr) == i);
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero register and bulk clear.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp import regfile_pkg::*; #(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned NUM_RD   = DEF_NUM_RD,
   parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
   input  logic      clk,
   input  logic      reset,
   regfile_if.slave  bus
);

   localparam int unsigned ADDR_W = $clog2(NUM_REGS);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic                clr_busy;
   logic                clr_done;
   logic [NUM_REGS-1:0] clr_vec_c;
   logic                wr_commit_c;

   // Implemented, non-zero register: the only addresses that hold state.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (32'(a) < NUM_REGS) && (32'(a) != ZERO_REG);
   endfunction

   regfile_clr_fsm #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_clr_fsm (
      .clk       (clk),
      .reset     (reset),
      .clr_req   (bus.clr_req),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .clr_vec_c (clr_vec_c)
   );

   assign bus.clr_busy = clr_busy;
   assign bus.clr_done = clr_done;

   assign wr_commit_c = reset & bus.wr_en & ~clr_busy & addr_ok(bus.wr_addr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (clr_vec_c[i]) begin
               regs[i] <= '0;
            end else if (wr_commit_c && (32'(bus.wr_addr) == i)) begin
               regs[i] <= bus.wr_data;
            end
         end
      end
   end

   // Independent combinational read ports.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      bus.rd_data = '0;
      ra          = '0;
      rv          = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
         rv = addr_ok(ra) ? regs[ra] : '0;
`ifdef REGFILE_BYPASS_EN
         if (wr_commit_c && (ra == bus.wr_addr)) begin
            rv = bus.wr_data;
         end
`else
`endif
         bus.rd_data[p*DATA_W +: DATA_W] = rv;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised, model-checked bench for regfile_mp (honours REGFILE_BYPASS_EN when defined).
module tb_regfile_mp #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ZERO_REG = NUM_REGS - 1
);

   localparam int unsigned ADDR_W = $clog2(NUM_REGS);

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   regfile_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus ();

   regfile_mp #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   bit          cmp_en  = 1'b0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // age counts edges since a clear was accepted: 1..NUM_REGS busy, NUM_REGS+1 done, 0 idle.
   logic [DATA_W-1:0] mregs [NUM_REGS];
   int unsigned       age;

   function automatic bit valid(input int unsigned a);
      return (a < NUM_REGS) && (a != ZERO_REG);
   endfunction
   function automatic bit m_busy();
      return (age >= 1) && (age <= NUM_REGS);
   endfunction
   function automatic bit m_done();
      return age == NUM_REGS + 1;
   endfunction
   function automatic bit m_commit();
      return reset && bus.wr_en && !m_busy() && valid(32'(bus.wr_addr));
   endfunction
   function automatic logic [DATA_W-1:0] m_read(input int unsigned a);
      logic [DATA_W-1:0] v;
      v = valid(a) ? mregs[a] : '0;
`ifdef REGFILE_BYPASS_EN
      if (m_commit() && a == 32'(bus.wr_addr)) v = bus.wr_data;
`endif
      return v;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         foreach (mregs[i]) mregs[i] = '0;
         age = 0;
      end else begin
         if (m_commit()) mregs[32'(bus.wr_addr)] = bus.wr_data;
         if (m_busy()) mregs[age-1] = '0;
         if (age == 0) begin
            if (bus.clr_req) age = 1;
         end else if (age > NUM_REGS) age = 0;
         else age = age + 1;
      end
   end

   function automatic logic [DATA_W-1:0] rd_port(input int unsigned p);
      return bus.rd_data[p*DATA_W +: DATA_W];
   endfunction
   function automatic int unsigned rd_addr_of(input int unsigned p);
      return 32'(bus.rd_addr[p*ADDR_W +: ADDR_W]);
   endfunction

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int unsigned p = 0; p < NUM_RD; p++)
            chk($sformatf("cyc_rd%0d", p), rd_port(p), m_read(rd_addr_of(p)));
         chk("cyc_busy", DATA_W'(bus.clr_busy), DATA_W'(m_busy()));
         chk("cyc_done", DATA_W'(bus.clr_done), DATA_W'(m_done()));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int unsigned p, input int unsigned a);
      bus.rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
   endtask

   task automatic set_all_rd(input int unsigned a);
      for (int unsigned p = 0; p < NUM_RD; p++) set_rd(p, a);
   endtask

   task automatic wait_idle();
      int unsigned k;
      k = 0;
      while ((bus.clr_busy || bus.clr_done) && k < NUM_REGS + 8) begin
         step();
         k++;
      end
      chk("idle_timeout", DATA_W'(bus.clr_busy | bus.clr_done), '0);
   endtask

   task automatic fill();
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = ADDR_W'(i);
         bus.wr_data = DATA_W'(64'h0100_0000_0000_0001) + DATA_W'(i);
         step();
      end
      bus.wr_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int unsigned a = 0; a < NUM_REGS; a++) begin
         set_all_rd(a);
         #1;
         for (int unsigned p = 0; p < NUM_RD; p++) chk(tag, rd_port(p), '0);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int unsigned busy_cnt, done_cnt;
      bus.rd_addr = '0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.clr_req = 1'b0;
      #1;
      chk("rst_busy", DATA_W'(bus.clr_busy), '0);
      chk("rst_done", DATA_W'(bus.clr_done), '0);
      chk("rst_rd0",  rd_port(0), '0);
      cmp_en = 1'b1;
      #20 reset = 1'b1;
      step();

      // Write then read on every port; zero-register writes are dropped.
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(5); bus.wr_data = DATA_W'(64'hDEAD_BEEF_0123_4567);
      step();
      bus.wr_en = 1'b0;
      set_all_rd(5);
      #1;
      for (int unsigned p = 0; p < NUM_RD; p++)
         chk("r5_read", rd_port(p), DATA_W'(64'hDEAD_BEEF_0123_4567));
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(ZERO_REG); bus.wr_data = '1;
      step();
      bus.wr_en = 1'b0;
      set_all_rd(ZERO_REG);
      #1;
      chk("zero_reg", rd_port(0), '0);

      // Same-cycle write/read of r7.
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(7); bus.wr_data = DATA_W'(64'hAAAA);
      step();
      bus.wr_data = DATA_W'(64'h1234);
      set_rd(0, 7);
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_r7", rd_port(0), DATA_W'(64'h1234));
`else
      chk("nobypass_r7", rd_port(0), DATA_W'(64'hAAAA));
`endif
      step();
      bus.wr_en = 1'b0;
      #1;
      chk("r7_after", rd_port(0), DATA_W'(64'h1234));

      // Random traffic with occasional clears.
      for (int i = 0; i < 600; i++) begin
         bus.wr_en   = 1'($urandom_range(0, 1));
         bus.wr_addr = ADDR_W'($urandom);
         bus.wr_data = DATA_W'({$urandom, $urandom});
         bus.clr_req = ($urandom_range(0, 59) == 0);
         for (int unsigned p = 0; p < NUM_RD; p++) set_rd(p, $urandom);
         step();
      end
      bus.wr_en = 1'b0; bus.clr_req = 1'b0;
      wait_idle();

      // Asynchronous reset with loaded registers clears reads before any edge.
      fill();
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", DATA_W'(bus.clr_busy), '0);
      check_all_zero("arst_rd");
      reset = 1'b1;
      step();

      // Full sweep: busy for NUM_REGS cycles, a single done pulse, everything zero.
      fill();
      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int k = 0; k < int'(NUM_REGS) + 6; k++) begin
         if (bus.clr_busy) busy_cnt++;
         if (bus.clr_done) done_cnt++;
         step();
      end
      chk("sweep_busy_cycles", DATA_W'(busy_cnt), DATA_W'(NUM_REGS));
      chk("sweep_done_pulses", DATA_W'(done_cnt), DATA_W'(1));
      check_all_zero("sweep_rd");

      // Write in the accept cycle commits; write mid-sweep is dropped.
      fill();
      bus.clr_req = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(3); bus.wr_data = DATA_W'(64'h5555);
      step();
      bus.clr_req = 1'b0; bus.wr_en = 1'b0;
      set_rd(0, 3);
      #1;
      chk("accept_wr_r3", rd_port(0), DATA_W'(64'h5555));
      repeat (NUM_REGS - 4) step();
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(3); bus.wr_data = DATA_W'(64'h7777);
      step();
      bus.wr_en = 1'b0;
      wait_idle();
      set_rd(0, 3);
      #1;
      chk("sweep_wr_dropped", rd_port(0), '0);

      // Reset mid-sweep aborts without a done pulse.
      fill();
      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      repeat (10) step();
      #1;
      reset = 1'b0;
      #1;
      chk("abort_busy", DATA_W'(bus.clr_busy), '0);
      chk("abort_done", DATA_W'(bus.clr_done), '0);
      reset = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < int'(NUM_REGS) + 4; k++) begin
         if (bus.clr_done) done_cnt++;
         step();
      end
      chk("abort_no_done", DATA_W'(done_cnt), '0);
      check_all_zero("abort_rd");

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
